// File: rtl/stack_pkg.sv
// Shared definitions for the processor operand stack: default geometry and
// the per-cycle operation decode.
package stack_pkg;

    localparam int STACK_WIDTH = 8;
    localparam int STACK_DEPTH = 16;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPL,
        OP_TOS
    } op_e;

    // push+pop is a replace; tos is ignored whenever push or pop is present.
    function automatic op_e decode_op(input logic push, input logic pop, input logic tos);
        if (push && pop) return OP_REPL;
        else if (pop)    return OP_POP;
        else if (push)   return OP_PUSH;
        else if (tos)    return OP_TOS;
        else             return OP_IDLE;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x WIDTH array with one synchronous write port and one
// combinational read port. Contents are intentionally not reset.
module stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO operand stack with replace, registered read + valid
// strobe, occupancy status and sticky overflow/underflow flags.
module param_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic             err_clr,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Dout,
    output logic             dout_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] SP_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] SP_ONE  = CW'(1);

    logic [CW-1:0]    sp;
    logic [AW-1:0]    top_addr, push_addr, waddr;
    logic [WIDTH-1:0] rdata;
    logic             we, ovf_set, unf_set;
    op_e              op;

    assign count = sp;
    assign empty = (sp == '0);
    assign full  = (sp == SP_FULL);

    // Addresses are truncated; each is only consumed when sp makes it valid.
    assign top_addr  = AW'(sp - SP_ONE);
    assign push_addr = AW'(sp);

    assign op = decode_op(push, pop, tos);

    // A replace on an empty stack degenerates to a plain push at slot 0.
    assign we    = (op == OP_REPL) || (op == OP_PUSH && !full);
    assign waddr = (op == OP_REPL && !empty) ? top_addr : push_addr;

    assign ovf_set = (op == OP_PUSH) && full;
    assign unf_set = empty && (op == OP_REPL || op == OP_POP || op == OP_TOS);

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (Din),
        .raddr (top_addr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp         <= '0;
            Dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            case (op)
                OP_REPL: begin
                    if (empty) begin
                        sp <= SP_ONE;
                    end else begin
                        Dout       <= rdata;
                        dout_valid <= 1'b1;
                    end
                end
                OP_POP: begin
                    if (!empty) begin
                        Dout       <= rdata;
                        sp         <= sp - SP_ONE;
                        dout_valid <= 1'b1;
                    end
                end
                OP_PUSH: begin
                    if (!full) sp <= sp + SP_ONE;
                end
                OP_TOS: begin
                    if (!empty) begin
                        Dout       <= rdata;
                        dout_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Set takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_set | (overflow  & ~err_clr);
            underflow <= unf_set | (underflow & ~err_clr);
        end
    end

endmodule
